oam_write_port: RTL and testbench

Buffers sprite-attribute (OAM) writes issued by the CPU pipeline and commits them into the OAM RAM only on cycles when the PPU is not reading OAM. It sits between the CPU's memory stage (OAM write strobe, address, data) and the write port of the 256-byte OAM RAM. It also provides a hardware "clear all sprites" sweep. It raises a stall to the CPU whenever it cannot accept a write.

---
 rtl/oam_write_port.sv | 108 ++++++++++
 tb/tb_oam_write_port.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_write_port.sv
// OAM write buffer: queues CPU OAM writes and commits them on cycles the PPU
// leaves the OAM RAM port free; also runs a full-RAM clear sweep.
module oam_write_port #(
  parameter int              DEPTH     = 4,
  parameter int              AW        = 8,
  parameter int              DW        = 8,
  parameter logic [DW-1:0]   CLEAR_VAL = 8'hFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       oam_we,
  input  logic [AW-1:0]              oam_addr,
  input  logic [DW-1:0]              oam_wdata,
  input  logic                       oam_clear,
  input  logic                       ppu_busy,
  output logic                       stall,
  output logic                       ram_we,
  output logic [AW-1:0]              ram_addr,
  output logic [DW-1:0]              ram_wdata,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       idle
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, CLR_WAIT, CLR_SWEEP} state_t;

  state_t          state_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q, count_d;
  logic [AW-1:0]   sweep_q;
  logic [AW-1:0]   addr_mem [DEPTH];
  logic [DW-1:0]   data_mem [DEPTH];

  logic empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Head of the FIFO is shown combinationally so a write can commit the
  // cycle right after it is accepted.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_mem[rd_ptr_q];
    ram_wdata = data_mem[rd_ptr_q];
    stall     = 1'b1;
    case (state_q)
      RUN: begin
        ram_we = !empty && !ppu_busy;
        stall  = full;
      end
      CLR_WAIT: ram_we = !empty && !ppu_busy;
      CLR_SWEEP: begin
        ram_we    = !ppu_busy;
        ram_addr  = sweep_q;
        ram_wdata = CLEAR_VAL;
      end
      default: ;
    endcase
  end

  assign push    = oam_we && !stall;
  assign pop     = ram_we && (state_q != CLR_SWEEP);
  assign count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  assign pending = count_q;
  assign idle    = (state_q == RUN) && empty;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= oam_addr;
      data_mem[wr_ptr_q] <= oam_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sweep_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case (state_q)
        RUN: if (oam_clear && !stall) state_q <= CLR_WAIT;
        // No pushes happen outside RUN, so count_d == 0 covers both the
        // last-pop case and an already-empty FIFO.
        CLR_WAIT: if (count_d == '0) begin
          state_q <= CLR_SWEEP;
          sweep_q <= '0;
        end
        CLR_SWEEP: if (ram_we) begin
          if (sweep_q == '1) begin
            state_q <= RUN;
            sweep_q <= '0;
          end else begin
            sweep_q <= sweep_q + AW'(1);
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_write_port.sv
// Directed bench for oam_write_port: stimulus pushes expected commits into a
// queue, a negedge monitor pops and compares every ram_we cycle.
module tb_oam_write_port;
  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          oam_we = 1'b0;
  logic [AW-1:0] oam_addr = '0;
  logic [DW-1:0] oam_wdata = '0;
  logic          oam_clear = 1'b0;
  logic          ppu_busy = 1'b0;
  logic          stall, ram_we, idle;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [2:0]    pending;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  bit          mon_en = 1'b0;

  oam_write_port #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CLEAR_VAL(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .oam_we(oam_we), .oam_addr(oam_addr),
    .oam_wdata(oam_wdata), .oam_clear(oam_clear), .ppu_busy(ppu_busy),
    .stall(stall), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .pending(pending), .idle(idle)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [15:0] e;
    if (mon_en && rst_n && ram_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit: unexpected ram_we addr=%h data=%h, required no write", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({ram_addr, ram_wdata} !== e) begin
          errors++;
          $display("FAIL commit: got addr=%h data=%h, required addr=%h data=%h",
                   ram_addr, ram_wdata, e[15:8], e[7:0]);
        end else begin
          $display("commit addr=%h data=%h ok", ram_addr, ram_wdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (!idle && n < max) begin
      tick();
      n++;
    end
    chk("idle_reached", idle, 1);
  endtask

  task automatic set_write(input logic [7:0] a, input logic [7:0] d);
    oam_we    = 1'b1;
    oam_addr  = a;
    oam_wdata = d;
    exp_q.push_back({a, d});
  endtask

  initial begin
    int  n;
    bit  found;
    int  stray;

    // Reset
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_pending", pending, 0);
    chk("rst_idle", idle, 1);
    mon_en = 1'b1;

    // Single write, one-cycle latency
    tick();
    set_write(8'h10, 8'h3C);
    tick();
    oam_we = 1'b0;
    @(negedge clk);
    chk("single_ram_we", ram_we, 1);
    chk("single_addr", ram_addr, 8'h10);
    chk("single_data", ram_wdata, 8'h3C);
    chk("single_pending", pending, 1);
    tick();
    @(negedge clk);
    chk("single_pending_after", pending, 0);
    chk("single_idle_after", idle, 1);

    // Fill while PPU busy, full boundary
    tick();
    ppu_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_write(8'(i), 8'hA0 + 8'(i));
      tick();
    end
    set_write(8'h04, 8'hA4);
    @(negedge clk);
    chk("full_stall", stall, 1);
    chk("full_pending", pending, 4);
    chk("full_no_we", ram_we, 0);
    tick();
    ppu_busy = 1'b0;
    @(negedge clk);
    chk("full_stall_with_pop", stall, 1);
    chk("full_pop_we", ram_we, 1);
    tick();
    n = 0;
    while (stall && n < 10) begin
      tick();
      n++;
    end
    chk("fifth_accept_ready", stall, 0);
    tick();
    oam_we = 1'b0;
    wait_idle(20);
    chk("full_drained_pending", pending, 0);

    // Steady push+pop at count 2 across pointer wrap
    ppu_busy = 1'b1;
    set_write(8'h20, 8'h01); tick();
    set_write(8'h21, 8'h02); tick();
    ppu_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_write(8'h30 + 8'(i), 8'(i * 7));
      @(negedge clk);
      chk("stream_pending", pending, 2);
      tick();
    end
    oam_we = 1'b0;
    wait_idle(20);

    // Clear with two pending writes, busy toggling
    ppu_busy = 1'b1;
    set_write(8'h50, 8'h11); tick();
    set_write(8'h51, 8'h22); tick();
    oam_we = 1'b0;
    oam_clear = 1'b1;
    tick();
    oam_clear = 1'b0;
    for (int a = 0; a < 256; a++) exp_q.push_back({8'(a), 8'hFF});
    oam_we = 1'b1;
    oam_addr = 8'h77;
    oam_wdata = 8'h99;
    n = 0;
    while (!idle && n < 1000) begin
      if (n % 3 == 0) ppu_busy = ~ppu_busy;
      @(negedge clk);
      if (stall !== 1'b1) chk("sweep_stall", stall, 1);
      tick();
      n++;
    end
    oam_we = 1'b0;
    ppu_busy = 1'b0;
    chk("sweep_done_idle", idle, 1);
    chk("sweep_sb_empty", exp_q.size(), 0);
    chk("post_sweep_stall", stall, 0);
    set_write(8'h33, 8'h5A);
    tick();
    oam_we = 1'b0;
    @(negedge clk);
    chk("post_sweep_we", ram_we, 1);
    chk("post_sweep_pending", pending, 1);
    wait_idle(10);

    // Reset in the middle of a sweep
    tick();
    oam_clear = 1'b1;
    tick();
    oam_clear = 1'b0;
    for (int a = 0; a < 256; a++) exp_q.push_back({8'(a), 8'hFF});
    found = 1'b0;
    n = 0;
    while (!found && n < 400) begin
      @(negedge clk);
      if (ram_we && ram_addr == 8'h40) found = 1'b1;
      n++;
    end
    chk("sweep_reached_40", found, 1);
    #1 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midsweep_rst_we", ram_we, 0);
    chk("midsweep_rst_pending", pending, 0);
    chk("midsweep_rst_idle", idle, 1);
    chk("midsweep_rst_stall", stall, 0);
    stray = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ram_we) stray++;
    end
    chk("midsweep_no_more_writes", stray, 0);

    // Reset with a write pending
    tick();
    ppu_busy = 1'b1;
    set_write(8'h60, 8'h42);
    tick();
    oam_we = 1'b0;
    @(negedge clk);
    chk("pend_before_rst", pending, 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    ppu_busy = 1'b0;
    @(negedge clk);
    chk("pend_rst_pending", pending, 0);
    chk("pend_rst_we", ram_we, 0);
    chk("pend_rst_idle", idle, 1);
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_we) stray++;
    end
    chk("pend_rst_no_writes", stray, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
